// File: rtl/uart_rx_mmio_pkg.sv
// Shared definitions for the MMIO UART receiver.
// Contents: register offsets relative to BASE, STATUS bit positions,
// and the receive state machine encoding.
package uart_rx_mmio_pkg;

  localparam logic [31:0] OFF_DATA   = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd4;

  localparam int ST_AVAIL   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_mmio_rx_fifo.sv
// Synchronous byte FIFO, depth 2**FIFO_LOG2, first-word-fall-through output.
// Ports: clk/rst (sync, active-low), push/din write, pop read, dout = head,
// count/full/empty. The caller must not push when full unless popping too.
module rx_fifo #(
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic [FIFO_LOG2:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] PTR_ONE = 1;

  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [FIFO_LOG2:0] wr_q, wr_d;
  logic [FIFO_LOG2:0] rd_q, rd_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[FIFO_LOG2-1:0]] = din;
      wr_d = wr_q + PTR_ONE;
    end
    if (pop) begin
      rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The extra pointer MSB distinguishes full from empty.
  assign count = wr_q - rd_q;
  assign full  = (count == (FIFO_LOG2+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem_q[rd_q[FIFO_LOG2-1:0]];

endmodule

// File: rtl/uart_rx_mmio.sv
// MMIO UART receiver: 8N1 deserialiser feeding a receive FIFO, read via
// DATA (BASE, read pops) and STATUS (BASE+4, W1C flags). Ports: clk, rst
// (sync, active-low), rxd serial in, mem_* bus; reads answer one cycle later.
module uart_rx_mmio
  import uart_rx_mmio_pkg::*;
#(
  parameter int          DIVISOR   = 868,
  parameter int          FIFO_LOG2 = 4,
  parameter logic [31:0] BASE      = 32'hf0000104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        mem_oe,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready
);

  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIVISOR/2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIVISOR - 1);

  logic            sync1_q, rxs_q, rxs_prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            ovr_q, ovr_d;
  logic            ferr_q, ferr_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            push_req, ferr_set, ovr_set;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [FIFO_LOG2:0] fifo_count;
  logic            rd_access, wr_access, hit_data, hit_stat;
  logic            clr_ovr, clr_ferr;
  logic [31:0]     status;
  logic            unused_wdata;

  assign unused_wdata = ^{mem_wdata[31:4], mem_wdata[1:0]};

  // Receive state machine
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          cnt_d   = CNT_HALF;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            bit_d   = 3'd0;
            cnt_d   = CNT_FULL;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          sh_d  = {rxs_q, sh_q[7:1]};
          cnt_d = CNT_FULL;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BREAK: begin
        // A line held low must go high before a new start can be seen.
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus decode, FIFO control, flags and read response
  always_comb begin
    rd_access = mem_oe && (mem_we == 4'b0000);
    wr_access = mem_oe && (mem_we != 4'b0000);
    hit_data  = (mem_addr == BASE + OFF_DATA);
    hit_stat  = (mem_addr == BASE + OFF_STATUS);

    fifo_pop  = rd_access && hit_data && !fifo_empty;
    // Fullness counts after a same-cycle pop, so push+pop on full succeeds.
    fifo_push = push_req && (!fifo_full || fifo_pop);
    ovr_set   = push_req && fifo_full && !fifo_pop;

    clr_ovr   = wr_access && hit_stat && mem_wdata[ST_OVR];
    clr_ferr  = wr_access && hit_stat && mem_wdata[ST_FERR];
    // Set wins over a coincident clear.
    ovr_d     = (ovr_q  && !clr_ovr)  || ovr_set;
    ferr_d    = (ferr_q && !clr_ferr) || ferr_set;

    status = '0;
    status[ST_AVAIL] = !fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVR]   = ovr_q;
    status[ST_FERR]  = ferr_q;
    status[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);

    ready_d = rd_access && (hit_data || hit_stat);
    rdata_d = '0;
    if (rd_access && hit_data && !fifo_empty) begin
      rdata_d = {24'b0, fifo_dout};
    end else if (rd_access && hit_stat) begin
      rdata_d = status;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      sync1_q    <= rxd;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

  rx_fifo #(.FIFO_LOG2(FIFO_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sh_q),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio with DIVISOR=8: directed serial frames and MMIO
// accesses; each read pushes its expected value, a negedge monitor pops and
// compares on every mem_ready pulse.
module tb_uart_rx_mmio;

  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'hf0000104;
  localparam logic [31:0] STAT = 32'hf0000108;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        mem_oe;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] mon_e;
  string       mon_t;

  always #5 clk = ~clk;

  uart_rx_mmio #(.DIVISOR(D), .FIFO_LOG2(4), .BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .mem_oe    (mem_oe),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
    mem_oe   = 1'b1;
    mem_addr = a;
    mem_we   = 4'h0;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    mem_oe   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_oe    = 1'b1;
    mem_addr  = a;
    mem_we    = 4'hf;
    mem_wdata = d;
    tick();
    mem_oe    = 1'b0;
    mem_we    = 4'h0;
    mem_wdata = '0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (D) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (D) tick();
    end
    rxd = stop;
    repeat (D) tick();
    if (stop) rxd = 1'b1;
  endtask

  // Monitor: every response must match the oldest outstanding read;
  // outside a response the data bus must be zero.
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready got=%h want=no_response", mem_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        if (mem_rdata !== mon_e) begin
          errors++;
          $display("FAIL %s got=%h want=%h", mon_t, mem_rdata, mon_e);
        end
      end
    end else begin
      checks++;
      if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_bus got ready=%b rdata=%h want ready=0 rdata=0",
                 mem_ready, mem_rdata);
      end
    end
  end

  initial begin
    rst = 1'b0; rxd = 1'b1; mem_oe = 1'b0;
    mem_addr = '0; mem_we = '0; mem_wdata = '0;
    repeat (3) tick();
    checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rdata=%h want ready=0 rdata=0",
               mem_ready, mem_rdata);
    end
    rst = 1'b1;
    tick();
    rd(STAT, 32'h0, "reset_status");

    // 1: good frame
    send_frame(8'h55, 1'b1);
    tick();
    rd(STAT, 32'h00000101, "t1_status");
    rd(BASE, 32'h00000055, "t1_data");
    rd(STAT, 32'h0, "t1_status_empty");
    wr(BASE, 32'hffffffff);
    rd(STAT, 32'h0, "t1_data_write_ignored");

    // 2: glitch shorter than half a bit is a false start
    rxd = 1'b0;
    repeat (2) tick();
    rxd = 1'b1;
    repeat (20) tick();
    rd(STAT, 32'h0, "t2_false_start");
    send_frame(8'h81, 1'b1);
    tick();
    rd(BASE, 32'h00000081, "t2_after_glitch");

    // 3: framing error followed by held-low line
    send_frame(8'hA3, 1'b0);
    repeat (30) tick();
    rxd = 1'b1;
    repeat (20) tick();
    rd(STAT, 32'h00000008, "t3_frame_err");
    rd(BASE, 32'h0, "t3_empty_data");
    wr(STAT, 32'h00000008);
    rd(STAT, 32'h0, "t3_w1c");

    // 4: overflow
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1);
    end
    tick();
    rd(STAT, 32'h00001007, "t4_full_overrun");
    for (int i = 0; i < 16; i++) begin
      rd(BASE, 32'(i), "t4_drain");
    end
    rd(BASE, 32'h0, "t4_read_empty");
    rd(STAT, 32'h00000004, "t4_overrun_sticky");
    wr(STAT, 32'h00000004);
    rd(STAT, 32'h0, "t4_overrun_clear");

    // 5: DATA read in the same cycle as the stop-bit push
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    tick();
    rd(STAT, 32'h00000301, "t5_pre_status");
    fork
      send_frame(8'h44, 1'b1);
      begin
        // Stop sample lands 78 cycles after the start bit is driven.
        repeat (78) tick();
        rd(BASE, 32'h00000011, "t5_pop_oldest");
      end
    join
    tick();
    rd(STAT, 32'h00000301, "t5_count_kept");
    rd(BASE, 32'h00000022, "t5_order_1");
    rd(BASE, 32'h00000033, "t5_order_2");
    rd(BASE, 32'h00000044, "t5_order_3");
    rd(STAT, 32'h0, "t5_empty");

    // 6: reset during data bit 4 with a byte already queued
    send_frame(8'h77, 1'b1);
    rxd = 1'b0;
    repeat (D) tick();
    for (int i = 0; i < 4; i++) begin
      rxd = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (D) tick();
    end
    rxd = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    rxd = 1'b1;
    tick();
    rst = 1'b1;
    repeat (20) tick();
    rd(STAT, 32'h0, "t6_after_reset");
    send_frame(8'h3C, 1'b1);
    tick();
    rd(STAT, 32'h00000101, "t6_status");
    rd(BASE, 32'h0000003C, "t6_data");

    repeat (5) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses got=%0d outstanding want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_mmio.md
# uart_rx_mmio

Memory-mapped UART receiver on the processor data bus: it deserialises 8N1 frames from a serial input line into a receive FIFO, which the processor reads through two MMIO registers. It is the receive-side counterpart of the existing console TX register at `0xf0000100`. It sits beside the other MMIO decoders in the `0xf` address region, and its `mem_ready`/`mem_rdata` are OR/muxed into the processor's bus response.

## Interface
Parameters:
- `DIVISOR`, 868: clock cycles per serial bit. Must be at least 4.
- `FIFO_LOG2`, 4: log2 of the receive FIFO depth. Default depth is 16.
- `BASE`, 32'hf0000104: address of the DATA register. STATUS is at `BASE+4`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset: synchronous, active-low
- `rxd`  in  1  serial input, asynchronous, idle-high
- `mem_oe`  in  1  bus access strobe, one cycle per request
- `mem_addr`  in  32  byte address
- `mem_we`  in  4  byte write enables; all zero means a read
- `mem_wdata`  in  32  write data
- `mem_rdata`  out  32  read data; valid only while `mem_ready`=1, otherwise 0
- `mem_ready`  out  1  one-cycle read-response pulse

## Operation
- A decoded access is `mem_oe` together with `mem_addr==BASE` or `mem_addr==BASE+4`. All other accesses are ignored.
- **DATA register (`BASE`)**
  - Read returns `{24'b0, byte}` and pops the FIFO head.
  - If the FIFO is empty, a read returns 0 and does not pop.
  - Writes are ignored.
- **STATUS register (`BASE+4`)**
  - bit0 `avail`: FIFO not empty.
  - bit1 `full`.
  - bit2 `overrun`: sticky.
  - bit3 `frame_err`: sticky.
  - bits[12:8] `count`: 0..2^FIFO_LOG2.
  - All other bits read 0.
  - A write with any `mem_we` bit set is write-1-to-clear: `wdata[2]` clears overrun, `wdata[3]` clears frame_err.
- **Input synchroniser:** `rxd` passes through a 2-flop synchroniser (`rxs`). Edge detection uses `rxs` and its previous value.
- **Receive state machine**
  - IDLE: on a falling edge of `rxs`, load `cnt=DIVISOR/2-1` and go to START.
  - START: when `cnt` reaches 0, sample `rxs`. If 1, it is a false start: go to IDLE. If 0, set `bit=0`, `cnt=DIVISOR-1`, go to DATA.
  - DATA: when `cnt` reaches 0, shift `rxs` into `sh` LSB-first. After the 8th bit, go to STOP. `cnt` reloads to `DIVISOR-1` at each sample.
  - STOP: when `cnt` reaches 0, sample `rxs`.
    - If 1 and the FIFO is not full, push `sh`.
    - If 1 and the FIFO is full, drop the byte and set overrun.
    - If 0, drop the byte, set frame_err, and go to BREAK.
    - Otherwise go to IDLE.
  - BREAK: wait for `rxs`=1, then go to IDLE. A held-low line does not retrigger.
- **Simultaneous events**
  - Push and pop in the same cycle: both take effect, count is unchanged, order is preserved.
  - Push into a full FIFO coinciding with a pop: the push succeeds and overrun is not set, because fullness is evaluated after the pop.
  - A W1C clear in the same cycle a flag is being set: the set wins.
- **Reset:** reset mid-frame abandons the frame. State returns to IDLE, the FIFO is emptied, both flags are cleared, and the synchroniser is preset to 1.

## Timing
- **Reset values:** `mem_ready`=0, `mem_rdata`=0; internally, FIFO empty, flags 0.
- **Read latency:** 1 cycle. A decoded read at cycle N gives `mem_ready`=1 with registered `mem_rdata` at N+1, for exactly one cycle.
- **Writes:** no `mem_ready` response.
- **STATUS snapshot:** the value reflects state at cycle N, before any same-cycle push, pop or clear.
- **Pop timing:** the DATA pop takes effect at N+1, so back-to-back DATA reads return consecutive bytes.
- **Frame sampling:** let t0 be the cycle `rxs` is first seen low (2–3 cycles after the `rxd` edge).
  - Start is checked at t0+DIVISOR/2.
  - Data bit i is sampled at t0+DIVISOR/2+(i+1)·DIVISOR.
  - Stop is sampled at t0+DIVISOR/2+9·DIVISOR.
  - The byte is visible in STATUS one cycle after the stop sample.
- **Counter width:** `cnt` is `$clog2(DIVISOR)` bits. Count is FIFO_LOG2+1 bits, with no wrap at full.

## Structure
- **Shared MMIO package:**
  - register offsets DATA=0 and STATUS=4
  - STATUS bit positions
  - state enum {IDLE, START, DATA, STOP, BREAK}
- **Sub-module `rx_fifo`:**
  - synchronous FIFO, parameter FIFO_LOG2
  - ports: push/pop/din/dout/count/full/empty
  - wrapping read/write pointers with an extra MSB
  - first-word-fall-through output

## Test plan
All scenarios use DIVISOR=8 and BASE=32'hf0000104.
1. Send frame 0x55 with a good stop bit, then read STATUS -> 32'h00000101. Read DATA -> 32'h00000055. Read STATUS -> 0.
2. Drive `rxd` low for 2 cycles, then high -> no push, STATUS=0, FSM back in IDLE.
3. Send 0xA3 with stop bit 0 and hold the line low for 30 cycles -> STATUS=32'h8, count 0, no retrigger. Write STATUS with wdata 32'h8 -> 0.
4. Send 17 frames 0x00..0x10 without reading -> STATUS=32'h1007 (count 16, full, overrun, avail). 16 DATA reads return 0x00..0x0F in order, and a 17th read returns 0.
5. Issue a DATA read in the same cycle as a stop-bit push with count=3 -> count stays 3, and the returned byte is the oldest.
6. Drive `rst`=0 for one cycle during data bit 4 of a frame -> STATUS=0. The next frame, 0x3C, is received correctly.
